// File: rtl/adder_n_pkg.sv
// Shared arithmetic constants for the integer add primitive and its benches.
package adder_n_pkg;

  localparam int DEFAULT_N = 32;

endpackage

// File: rtl/adder_n_full_adder.sv
// Single-bit full adder used as one stage of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p     = a ^ b;
  assign s     = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);

endmodule

// File: rtl/adder_n.sv
// N-bit ripple-carry adder with combinational result and a registered copy.
module adder_n
  import adder_n_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic [N-1:0] sum_q,
  output logic         c_out_q
);

  logic [N:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_stage
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (c[i]),
      .s     (sum[i]),
      .c_out (c[i+1])
    );
  end

  assign c_out = c[N];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum;
      c_out_q <= c_out;
    end
  end

endmodule

// File: tb/tb_adder_n.sv
// Scoreboard bench for adder_n: stimulus queues expectations, a monitor checks them.
`timescale 1ns/100ps
module tb_adder_n;
  import adder_n_pkg::*;

  localparam int N = DEFAULT_N;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic [N-1:0] sum;
  logic         c_out;
  logic [N-1:0] sum_q;
  logic         c_out_q;

  adder_n #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
    .sum     (sum),
    .c_out   (c_out),
    .sum_q   (sum_q),
    .c_out_q (c_out_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    bit           reg_path;
    logic [N-1:0] s;
    logic         c;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [N-1:0] got_s, input logic got_c,
                       input logic [N-1:0] exp_s, input logic exp_c);
    checks++;
    if (got_s !== exp_s || got_c !== exp_c) begin
      errors++;
      $display("FAIL %s: got sum=%h c=%b, expected sum=%h c=%b", name, got_s, got_c, exp_s, exp_c);
    end
  endtask

  task automatic expect_out(input string name, input bit reg_path,
                            input logic [N-1:0] s, input logic c);
    exp_t e;
    e.name = name;
    e.reg_path = reg_path;
    e.s = s;
    e.c = c;
    q.push_back(e);
    -> sample_ev;
  endtask

  task automatic apply(input string name, input logic [N-1:0] va, input logic [N-1:0] vb,
                       input logic vc, input logic [N-1:0] exp_s, input logic exp_c);
    a = va;
    b = vb;
    c_in = vc;
    #1;
    expect_out(name, 1'b0, exp_s, exp_c);
    #1;
  endtask

  // Monitor: drains the scoreboard each time the stimulus marks outputs as settled.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.reg_path) check(e.name, sum_q, c_out_q, e.s, e.c);
        else            check(e.name, sum, c_out, e.s, e.c);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] ra, rb, wa, wb, exp_s;
    logic [N:0]   full;
    logic         exp_c;

    rst = 1'b1; a = 32'd5; b = 32'd7; c_in = 1'b0;
    #2;
    expect_out("reset_state_q", 1'b1, '0, 1'b0);
    expect_out("comb_during_reset", 1'b0, 32'd12, 1'b0);
    rst = 1'b0;
    #1;
    expect_out("release_holds_zero", 1'b1, '0, 1'b0);
    @(posedge clk); #1;
    expect_out("reg_5_plus_7", 1'b1, 32'd12, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_out("midstream_reset_q", 1'b1, '0, 1'b0);
    expect_out("midstream_reset_comb", 1'b0, 32'd12, 1'b0);
    #2 rst = 1'b0;
    #1;
    expect_out("after_release_q", 1'b1, '0, 1'b0);
    @(posedge clk); #1;
    expect_out("recapture_q", 1'b1, 32'd12, 1'b0);
    #1;

    apply("msb_carry",      32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
    apply("to_msb",         32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
    apply("cin_wrap",       32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
    apply("max_all",        32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    apply("b_wrap",         32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    apply("zero",           32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    apply("cin_only",       32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0);
    apply("alt_pattern",    32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1);
    apply("mid_ripple",     32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0);
    apply("mixed",          32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0);

    for (int k = 0; k < 128; k++) begin
      ra = $urandom;
      rb = $urandom;
      full = {1'b0, ra} + {1'b0, rb};
      apply($sformatf("random_%0d", k), ra, rb, 1'b0, full[N-1:0], full[N]);
    end

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        wa = '0; wa[i] = 1'b1;
        wb = '0; wb[j] = 1'b1;
        if (i == j && i == N - 1) begin
          exp_s = '0;
          exp_c = 1'b1;
        end else if (i == j) begin
          exp_s = '0;
          exp_s[i+1] = 1'b1;
          exp_c = 1'b0;
        end else begin
          exp_s = wa | wb;
          exp_c = 1'b0;
        end
        apply($sformatf("walk_%0d_%0d", i, j), wa, wb, 1'b0, exp_s, exp_c);
      end
    end

    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_n.md
# adder_n

Parameterised N-bit ripple-carry adder with carry-in and carry-out. The primary outputs are purely combinational. A registered copy of the result is also provided for use on clocked datapaths. The block serves as the integer add primitive for ALU and address-generation paths. It is built from a chain of single-bit full adders.

## Interface
Parameters:
- N, default 32: operand and result width in bits; legal for N ≥ 1.

Ports:
- clk  input  1  rising-edge clock; drives only the registered outputs.
- rst  input  1  reset, asynchronous and active-high; clears only the registered outputs.
- a  input  N  operand A, unsigned.
- b  input  N  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- sum  output  N  combinational result, (a + b + c_in) mod 2^N.
- c_out  output  1  combinational carry out of bit N-1.
- sum_q  output  N  sum registered on the rising edge of clk.
- c_out_q  output  1  c_out registered on the rising edge of clk.

## Operation
- Result rule: {c_out, sum} = a + b + c_in, evaluated at N+1 bits with no truncation before the carry is extracted.
- Structure rule: bit i is a full adder.
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c[0] = c_in and c_out = c[N].
- No signed interpretation and no overflow flag. Callers derive signed overflow externally from the operand MSBs and sum[N-1].
- Wrap-around: the all-ones operand plus 1 (from b or c_in) gives sum = 0 and c_out = 1.
- Simultaneous carry sources: the maximum input a = b = 2^N-1 with c_in = 1 gives sum = 2^N-1 and c_out = 1.
- X/Z on any input bit propagates to the affected sum bits and the carry chain. No masking.

## Timing
- sum and c_out are combinational with zero-cycle latency. In simulation they must settle within 1 ns of any input change, with no # delays in the RTL.
- sum_q and c_out_q have one-cycle latency: they take {sum, c_out} at each rising edge of clk.
- Reset:
  - While rst = 1, sum_q = 0 and c_out_q = 0, immediately and independent of clk.
  - sum and c_out are unaffected by rst.
- Reset released between edges: the registered outputs stay 0 until the next rising edge, then capture the current result.
- Reset asserted mid-stream: the registered outputs clear at once. No pending value is retained.
- There is no enable. The registers update on every edge.

## Structure
- Shared package (the team's arithmetic package): the default width constant, set to 32. Both adder_n and the testbenches reference it.
- Sub-module full_adder: inputs a, b, c_in; outputs s, c_out. Instantiated N times in a generate loop that chains each carry into the next stage.
- adder_n top level contains:
  - the carry vector c[N:0]
  - the generate chain
  - one always_ff block with the asynchronous reset for sum_q and c_out_q.
- No carry-lookahead. Ripple is the required architecture so that the area is predictable.

## Test plan
- Random: 128 pairs of a, b from $urandom, c_in = 0. After 1 ns, sum must equal a + b truncated to 32 bits, and c_out must equal bit 32 of the full sum.
- Walking ones: for all i, j in 0..31, set a = 1<<i and b = 1<<j.
  - sum must equal a + b.
  - i = j = 31 must give sum = 0 and c_out = 1.
  - i = j < 31 must give sum = 1<<(i+1).
- Carry-out: a = 0x80000000, b = 0x80000000, c_in = 0 gives sum = 0x00000000 and c_out = 1. a = 0x7FFFFFFF, b = 1 gives sum = 0x80000000 and c_out = 0.
- Carry-in: a = 0xFFFFFFFF, b = 0, c_in = 1 gives sum = 0 and c_out = 1. a = 0xFFFFFFFF, b = 0xFFFFFFFF, c_in = 1 gives sum = 0xFFFFFFFF and c_out = 1.
- Registered path and reset:
  - Apply a = 5, b = 7 and clock once: sum_q = 12 and c_out_q = 0.
  - Assert rst between edges: sum_q = 0 immediately while sum stays 12.
  - Deassert rst: sum_q returns to 12 at the next rising edge.
